// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified DataMem port between instruction fetch and the load/store stage.
// One access is issued per MEM_LAT cycles; data wins contention unless fetch has been starved STARVE_MAX times.
module mem_port_arbiter #(
  parameter int          MEM_LAT    = 2,
  parameter logic [31:0] DATA_BASE  = 32'd48,
  parameter int          STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_func3,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  localparam logic [1:0] LAT_LOAD   = 2'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] WORD_FUNC3 = 3'b010;

  state_t      state, state_nxt;
  logic [1:0]  lat_cnt, lat_cnt_nxt;
  logic [3:0]  starve_cnt, starve_cnt_nxt;
  logic        flush_pend, flush_pend_nxt;

  logic        complete;
  logic        can_issue;
  logic        if_wins;

  function automatic logic [31:0] fetch_addr(input logic [31:0] a);
    return {a[31:1], 1'b0};
  endfunction

  function automatic logic [31:0] data_addr(input logic [31:0] a);
    return a + DATA_BASE;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lat_cnt    <= 2'd0;
      starve_cnt <= 4'd0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      starve_cnt <= starve_cnt_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    lat_cnt_nxt    = lat_cnt;
    starve_cnt_nxt = starve_cnt;
    flush_pend_nxt = flush_pend;
    if_gnt         = 1'b0;
    d_gnt          = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = 32'd0;
    mem_func3      = 3'd0;
    mem_wdata      = 32'd0;
    if_rvalid      = 1'b0;
    d_done         = 1'b0;
    if_rdata       = 32'd0;
    d_rdata        = 32'd0;

    busy      = (state != IDLE);
    complete  = (state != IDLE) && (lat_cnt == 2'd0);
    // The completion cycle doubles as the next issue slot; rst gates grants while reset is held.
    can_issue = rst && ((state == IDLE) || complete);
    if_wins   = if_req && (!d_req || (starve_cnt == STARVE_LIM));

    if (can_issue) begin
      if_gnt = if_wins;
      d_gnt  = d_req && !if_wins;
    end

    if (complete && (state == BUSY_IF) && !flush_pend && !if_flush) begin
      if_rvalid = 1'b1;
      if_rdata  = mem_rdata;
    end
    if (complete && (state == BUSY_D)) begin
      d_done  = 1'b1;
      d_rdata = mem_rdata;
    end

    if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = fetch_addr(if_addr);
      mem_func3 = WORD_FUNC3;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = data_addr(d_addr);
      mem_func3 = d_func3;
      mem_wdata = d_wdata;
    end

    if (if_gnt) begin
      state_nxt   = BUSY_IF;
      lat_cnt_nxt = LAT_LOAD;
    end else if (d_gnt) begin
      state_nxt   = BUSY_D;
      lat_cnt_nxt = LAT_LOAD;
    end else if (complete) begin
      state_nxt   = IDLE;
      lat_cnt_nxt = 2'd0;
    end else if (state != IDLE) begin
      lat_cnt_nxt = lat_cnt - 2'd1;
    end

    // A flush in the issue slot only marks a fetch granted in that same slot.
    if (can_issue) begin
      flush_pend_nxt = if_gnt && if_flush;
    end else if ((state == BUSY_IF) && if_flush) begin
      flush_pend_nxt = 1'b1;
    end

    if (if_gnt || !if_req) begin
      starve_cnt_nxt = 4'd0;
    end else if (d_gnt && (starve_cnt != STARVE_LIM)) begin
      starve_cnt_nxt = starve_cnt + 4'd1;
    end
  end

endmodule
